// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: date-setting FSM states,
// edit field codes, BCD range constants and small BCD digit helpers.
package clock_pkg;

  typedef enum logic [2:0] {
    DS_IDLE       = 3'd0,
    DS_EDIT_YEAR  = 3'd1,
    DS_EDIT_MONTH = 3'd2,
    DS_EDIT_DAY   = 3'd3,
    DS_COMMIT     = 3'd4
  } date_set_state_t;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_YEAR  = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_DAY   = 2'd3;

  localparam logic [7:0] BCD_MONTH_MIN   = 8'h01;
  localparam logic [7:0] BCD_MONTH_MAX   = 8'h12;
  localparam logic [7:0] BCD_DAY_MIN     = 8'h01;
  localparam logic [7:0] BCD_YEAR_BASE   = 8'h20;
  localparam logic [7:0] BCD_YEAR_LO_MIN = 8'h00;
  localparam logic [7:0] BCD_YEAR_LO_MAX = 8'h99;

  localparam logic [15:0] RESET_YEAR  = 16'h2019;
  localparam logic [7:0]  RESET_MONTH = 8'h01;
  localparam logic [7:0]  RESET_DAY   = 8'h01;

  // Two-digit BCD increment; the caller handles wrap at the range top.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD decrement; the caller handles wrap at the range bottom.
  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/month_days.sv
// Number of days in a month (BCD) for a year in 2000-2099, given only the
// low two year digits. Leap test works directly on the BCD digits.
module month_days (
  input  logic [7:0] month,
  input  logic [3:0] year1,
  input  logic [3:0] year0,
  output logic [7:0] max_day
);

  logic leap;

  // Leap year when the two-digit year is a multiple of 4, then month length lookup.
  always_comb begin
    if (year1[0]) leap = (year0 == 4'd2) || (year0 == 4'd6);
    else          leap = (year0 == 4'd0) || (year0 == 4'd4) || (year0 == 4'd8);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
      8'h02:                      max_day = leap ? 8'h29 : 8'h28;
      default:                    max_day = 8'h31;
    endcase
  end

endmodule

// File: rtl/date_set_ctrl.sv
// Date-setting controller: turns debounced key pulses into an edit session
// over a shadow copy of the date, and loads the date counter on confirm.
// Key pulses are registered once, so each key acts one cycle after it is sampled.
module date_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [31:0] IDLE_TIMEOUT = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_confirm,
  input  logic [3:0] year3,
  input  logic [3:0] year2,
  input  logic [3:0] year1,
  input  logic [3:0] year0,
  input  logic [3:0] month1,
  input  logic [3:0] month0,
  input  logic [3:0] day1,
  input  logic [3:0] day0,
  output logic [3:0] year_set3,
  output logic [3:0] year_set2,
  output logic [3:0] year_set1,
  output logic [3:0] year_set0,
  output logic [3:0] month_set1,
  output logic [3:0] month_set0,
  output logic [3:0] day_set1,
  output logic [3:0] day_set0,
  output logic       date_set_mod,
  output logic       editing,
  output logic [1:0] field_sel
);

  date_set_state_t state_q, state_d;
  logic [7:0]  year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mode_q, inc_q, dec_q, confirm_q;

  logic        step_up, step_dn;
  logic [7:0]  year_up, year_dn, month_up, month_dn, day_up, day_dn;
  logic [7:0]  cur_max, cand_max, cand_year, cand_month, day_clamped;

  // The century digits are fixed at 20, so the live upper year digits carry no information.
  logic unused_live_hi;
  assign unused_live_hi = ^{year3, year2};

  // Register the key pulses so every decision below sees a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      mode_q    <= key_mode;
      inc_q     <= key_inc;
      dec_q     <= key_dec;
      confirm_q <= key_confirm;
    end
  end

  assign step_up = inc_q & ~dec_q;
  assign step_dn = dec_q & ~inc_q;

  assign year_up  = (year_q == BCD_YEAR_LO_MAX) ? BCD_YEAR_LO_MIN : bcd2_inc(year_q);
  assign year_dn  = (year_q == BCD_YEAR_LO_MIN) ? BCD_YEAR_LO_MAX : bcd2_dec(year_q);
  assign month_up = (month_q >= BCD_MONTH_MAX) ? BCD_MONTH_MIN : bcd2_inc(month_q);
  assign month_dn = (month_q <= BCD_MONTH_MIN) ? BCD_MONTH_MAX : bcd2_dec(month_q);
  assign day_up   = (day_q >= cur_max) ? BCD_DAY_MIN : bcd2_inc(day_q);
  assign day_dn   = (day_q <= BCD_DAY_MIN) ? cur_max : bcd2_dec(day_q);

  assign cand_year  = (state_q == DS_EDIT_YEAR && step_up)  ? year_up  :
                      (state_q == DS_EDIT_YEAR && step_dn)  ? year_dn  : year_q;
  assign cand_month = (state_q == DS_EDIT_MONTH && step_up) ? month_up :
                      (state_q == DS_EDIT_MONTH && step_dn) ? month_dn : month_q;
  assign day_clamped = (day_q > cand_max) ? cand_max : day_q;

  month_days u_cur_days (
    .month   (month_q),
    .year1   (year_q[7:4]),
    .year0   (year_q[3:0]),
    .max_day (cur_max)
  );

  month_days u_cand_days (
    .month   (cand_month),
    .year1   (cand_year[7:4]),
    .year0   (cand_year[3:0]),
    .max_day (cand_max)
  );

  // State, shadow date and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DS_IDLE;
      year_q  <= RESET_YEAR[7:0];
      month_q <= RESET_MONTH;
      day_q   <= RESET_DAY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and shadow updates: confirm beats mode, mode beats inc/dec, silence counts toward timeout.
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    cnt_d   = cnt_q;
    case (state_q)
      DS_IDLE: begin
        cnt_d = '0;
        if (mode_q) begin
          state_d = DS_EDIT_YEAR;
          year_d  = {year1, year0};
          month_d = {month1, month0};
          day_d   = {day1, day0};
        end
      end
      DS_EDIT_YEAR, DS_EDIT_MONTH, DS_EDIT_DAY: begin
        if (confirm_q) begin
          state_d = DS_COMMIT;
          cnt_d   = '0;
        end else if (mode_q) begin
          cnt_d = '0;
          case (state_q)
            DS_EDIT_YEAR:  state_d = DS_EDIT_MONTH;
            DS_EDIT_MONTH: state_d = DS_EDIT_DAY;
            default:       state_d = DS_EDIT_YEAR;
          endcase
        end else if (inc_q || dec_q) begin
          cnt_d = '0;
          if (step_up || step_dn) begin
            case (state_q)
              DS_EDIT_YEAR: begin
                year_d = cand_year;
                day_d  = day_clamped;
              end
              DS_EDIT_MONTH: begin
                month_d = cand_month;
                day_d   = day_clamped;
              end
              default: day_d = step_up ? day_up : day_dn;
            endcase
          end
        end else if (cnt_q >= IDLE_TIMEOUT - 32'd1) begin
          state_d = DS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DS_COMMIT: begin
        state_d = DS_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = DS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    date_set_mod = 1'b0;
    editing      = 1'b0;
    field_sel    = FIELD_NONE;
    case (state_q)
      DS_EDIT_YEAR: begin
        editing   = 1'b1;
        field_sel = FIELD_YEAR;
      end
      DS_EDIT_MONTH: begin
        editing   = 1'b1;
        field_sel = FIELD_MONTH;
      end
      DS_EDIT_DAY: begin
        editing   = 1'b1;
        field_sel = FIELD_DAY;
      end
      DS_COMMIT: date_set_mod = 1'b1;
      default: ;
    endcase
  end

  assign year_set3  = BCD_YEAR_BASE[7:4];
  assign year_set2  = BCD_YEAR_BASE[3:0];
  assign year_set1  = year_q[7:4];
  assign year_set0  = year_q[3:0];
  assign month_set1 = month_q[7:4];
  assign month_set0 = month_q[3:0];
  assign day_set1   = day_q[7:4];
  assign day_set0   = day_q[3:0];

endmodule

// File: tb/tb_date_set_ctrl.sv
// Testbench for date_set_ctrl: directed scenarios plus random key traffic,
// all compared against a calendar-level reference model using plain integers.
module tb_date_set_ctrl;

  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic k_mode = 1'b0, k_inc = 1'b0, k_dec = 1'b0, k_conf = 1'b0;
  int   live_y = 2019, live_m = 1, live_d = 1;

  logic [3:0] year3, year2, year1, year0, month1, month0, day1, day0;
  logic [3:0] year_set3, year_set2, year_set1, year_set0;
  logic [3:0] month_set1, month_set0, day_set1, day_set0;
  logic       date_set_mod, editing;
  logic [1:0] field_sel;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  // Reference model state: 0 idle, 1 year, 2 month, 3 day, 4 commit
  int   m_state = 0, m_year = 2019, m_month = 1, m_day = 1, m_idle = 0, m_max = 31;
  logic p_mode = 1'b0, p_inc = 1'b0, p_dec = 1'b0, p_conf = 1'b0;

  function automatic logic [7:0] to_bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int mdays(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  assign {year3, year2}   = to_bcd8(live_y / 100);
  assign {year1, year0}   = to_bcd8(live_y % 100);
  assign {month1, month0} = to_bcd8(live_m);
  assign {day1, day0}     = to_bcd8(live_d);

  date_set_ctrl #(.IDLE_TIMEOUT(32'd10)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_mode     (k_mode),
    .key_inc      (k_inc),
    .key_dec      (k_dec),
    .key_confirm  (k_conf),
    .year3        (year3),
    .year2        (year2),
    .year1        (year1),
    .year0        (year0),
    .month1       (month1),
    .month0       (month0),
    .day1         (day1),
    .day0         (day0),
    .year_set3    (year_set3),
    .year_set2    (year_set2),
    .year_set1    (year_set1),
    .year_set0    (year_set0),
    .month_set1   (month_set1),
    .month_set0   (month_set0),
    .day_set1     (day_set1),
    .day_set0     (day_set0),
    .date_set_mod (date_set_mod),
    .editing      (editing),
    .field_sel    (field_sel)
  );

  always #5 clk = ~clk;

  // Count strobe cycles using the value held just before each rising edge.
  always @(posedge clk) begin
    if (date_set_mod === 1'b1) strobe_cnt++;
  end

  // Calendar-level model: a key sampled at one edge takes effect at the next.
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_year = 2019; m_month = 1; m_day = 1; m_idle = 0;
      p_mode = 1'b0; p_inc = 1'b0; p_dec = 1'b0; p_conf = 1'b0;
    end else begin
      case (m_state)
        0: if (p_mode) begin
          m_year = live_y; m_month = live_m; m_day = live_d; m_state = 1; m_idle = 0;
        end
        1, 2, 3: begin
          if (p_conf) m_state = 4;
          else if (p_mode) begin
            m_state = (m_state == 3) ? 1 : m_state + 1;
            m_idle = 0;
          end else if (p_inc || p_dec) begin
            m_idle = 0;
            if (p_inc != p_dec) begin
              if (m_state == 1) begin
                if (p_inc) m_year = (m_year == 2099) ? 2000 : m_year + 1;
                else       m_year = (m_year == 2000) ? 2099 : m_year - 1;
                if (m_day > mdays(m_month, m_year)) m_day = mdays(m_month, m_year);
              end else if (m_state == 2) begin
                if (p_inc) m_month = (m_month == 12) ? 1 : m_month + 1;
                else       m_month = (m_month == 1) ? 12 : m_month - 1;
                if (m_day > mdays(m_month, m_year)) m_day = mdays(m_month, m_year);
              end else begin
                m_max = mdays(m_month, m_year);
                if (p_inc) m_day = (m_day >= m_max) ? 1 : m_day + 1;
                else       m_day = (m_day <= 1) ? m_max : m_day - 1;
              end
            end
          end else if (m_idle == TIMEOUT - 1) begin
            m_state = 0; m_idle = 0;
          end else m_idle++;
        end
        default: m_state = 0;
      endcase
      p_mode = k_mode; p_inc = k_inc; p_dec = k_dec; p_conf = k_conf;
    end
  end

  function automatic logic [35:0] dut_vec();
    return {year_set3, year_set2, year_set1, year_set0, month_set1, month_set0,
            day_set1, day_set0, date_set_mod, editing, field_sel};
  endfunction

  function automatic logic [35:0] exp_vec();
    logic [1:0] fs;
    fs = (m_state >= 1 && m_state <= 3) ? 2'(m_state) : 2'd0;
    return {to_bcd8(m_year / 100), to_bcd8(m_year % 100), to_bcd8(m_month), to_bcd8(m_day),
            (m_state == 4), (m_state >= 1 && m_state <= 3), fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic c);
    k_mode = m; k_inc = i; k_dec = d; k_conf = c;
    tick();
    k_mode = 1'b0; k_inc = 1'b0; k_dec = 1'b0; k_conf = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_live(input int y, input int m, input int d);
    live_y = y; live_m = m; live_d = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (dut_vec() !== {16'h2019, 8'h01, 8'h01, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("[TB] FAIL reset_in got=%h want=%h", dut_vec(), {16'h2019, 8'h01, 8'h01, 4'h0});
    end
    rst = 1'b0;
    tick();
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL reset_out got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_entry();
    set_live(2023, 6, 15);
    press(1, 0, 0, 0);
    total++;
    if (dut_vec() !== {16'h2023, 8'h06, 8'h15, 1'b0, 1'b1, 2'd1}) begin
      bad++; $display("[TB] FAIL entry got=%h want=%h", dut_vec(), {16'h2023, 8'h06, 8'h15, 4'h5});
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL entry_model got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_year_wrap();
    do_reset();
    set_live(2099, 3, 10);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    total++;
    if (dut_vec() !== {16'h2000, 8'h03, 8'h10, 1'b0, 1'b1, 2'd1}) begin
      bad++; $display("[TB] FAIL year_inc_wrap got=%h want=%h", dut_vec(), {16'h2000, 8'h03, 8'h10, 4'h5});
    end
    press(0, 0, 1, 0);
    total++;
    if (dut_vec() !== {16'h2099, 8'h03, 8'h10, 1'b0, 1'b1, 2'd1}) begin
      bad++; $display("[TB] FAIL year_dec_wrap got=%h want=%h", dut_vec(), {16'h2099, 8'h03, 8'h10, 4'h5});
    end
  endtask

  task automatic test_leap_clamp();
    do_reset();
    set_live(2024, 1, 31);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    total++;
    if (dut_vec() !== {16'h2024, 8'h02, 8'h29, 1'b0, 1'b1, 2'd2}) begin
      bad++; $display("[TB] FAIL leap_clamp got=%h want=%h", dut_vec(), {16'h2024, 8'h02, 8'h29, 4'h6});
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    total++;
    if (dut_vec() !== {16'h2025, 8'h02, 8'h28, 1'b0, 1'b1, 2'd1}) begin
      bad++; $display("[TB] FAIL year_clamp got=%h want=%h", dut_vec(), {16'h2025, 8'h02, 8'h28, 4'h5});
    end
  endtask

  task automatic test_day_wrap();
    do_reset();
    set_live(2023, 4, 30);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    total++;
    if (dut_vec() !== {16'h2023, 8'h04, 8'h01, 1'b0, 1'b1, 2'd3}) begin
      bad++; $display("[TB] FAIL day_inc_wrap got=%h want=%h", dut_vec(), {16'h2023, 8'h04, 8'h01, 4'h7});
    end
    press(0, 0, 1, 0);
    total++;
    if (dut_vec() !== {16'h2023, 8'h04, 8'h30, 1'b0, 1'b1, 2'd3}) begin
      bad++; $display("[TB] FAIL day_dec_wrap got=%h want=%h", dut_vec(), {16'h2023, 8'h04, 8'h30, 4'h7});
    end
    press(0, 1, 1, 0);
    total++;
    if (dut_vec() !== {16'h2023, 8'h04, 8'h30, 1'b0, 1'b1, 2'd3}) begin
      bad++; $display("[TB] FAIL inc_dec_both got=%h want=%h", dut_vec(), {16'h2023, 8'h04, 8'h30, 4'h7});
    end
  endtask

  task automatic test_commit();
    int s0;
    do_reset();
    set_live(2021, 12, 31);
    press(1, 0, 0, 0);
    s0 = strobe_cnt;
    press(0, 0, 0, 1);
    total++;
    if (dut_vec() !== {16'h2021, 8'h12, 8'h31, 1'b1, 1'b0, 2'd0}) begin
      bad++; $display("[TB] FAIL commit_strobe got=%h want=%h", dut_vec(), {16'h2021, 8'h12, 8'h31, 4'h8});
    end
    set_live(2030, 7, 20);
    repeat (3) tick();
    total++;
    if (dut_vec() !== {16'h2021, 8'h12, 8'h31, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("[TB] FAIL commit_after got=%h want=%h", dut_vec(), {16'h2021, 8'h12, 8'h31, 4'h0});
    end
    total++;
    if (strobe_cnt - s0 !== 1) begin
      bad++; $display("[TB] FAIL strobe_width got=%0d want=1", strobe_cnt - s0);
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    total++;
    if (dut_vec() !== {16'h2030, 8'h07, 8'h20, 1'b0, 1'b1, 2'd2}) begin
      bad++; $display("[TB] FAIL second_session got=%h want=%h", dut_vec(), {16'h2030, 8'h07, 8'h20, 4'h6});
    end
    s0 = strobe_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (dut_vec() !== {16'h2019, 8'h01, 8'h01, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("[TB] FAIL abort_reset got=%h want=%h", dut_vec(), {16'h2019, 8'h01, 8'h01, 4'h0});
    end
    repeat (2) tick();
    total++;
    if (strobe_cnt !== s0 || dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL no_strobe_after_reset strobes=%0d want=%0d got=%h", strobe_cnt - s0, 0, dut_vec());
    end
  endtask

  task automatic test_timeout();
    int s0;
    int n;
    do_reset();
    set_live(2022, 5, 5);
    s0 = strobe_cnt;
    press(1, 0, 0, 0);
    n = 0;
    while (editing === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== TIMEOUT) begin
      bad++; $display("[TB] FAIL timeout_len got=%0d want=%0d", n, TIMEOUT);
    end
    total++;
    if (dut_vec() !== {16'h2022, 8'h05, 8'h05, 1'b0, 1'b0, 2'd0} || strobe_cnt !== s0) begin
      bad++; $display("[TB] FAIL timeout_idle got=%h strobes=%0d want=%h strobes=0",
                      dut_vec(), strobe_cnt - s0, {16'h2022, 8'h05, 8'h05, 4'h0});
    end
    press(1, 0, 0, 0);
    repeat (7) tick();
    press(0, 1, 0, 0);
    n = 0;
    while (editing === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== TIMEOUT) begin
      bad++; $display("[TB] FAIL timeout_restart got=%0d want=%0d", n, TIMEOUT);
    end
    total++;
    if (dut_vec() !== exp_vec() || strobe_cnt !== s0) begin
      bad++; $display("[TB] FAIL timeout_end got=%h want=%h strobes=%0d", dut_vec(), exp_vec(), strobe_cnt - s0);
    end
  endtask

  task automatic test_random();
    int y;
    int m;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        y = 2000 + int'($urandom_range(0, 99));
        m = int'($urandom_range(1, 12));
        set_live(y, m, int'($urandom_range(1, mdays(m, y))));
      end
      k_mode = ($urandom_range(0, 5) == 0);
      k_inc  = ($urandom_range(0, 2) == 0);
      k_dec  = ($urandom_range(0, 2) == 0);
      k_conf = ($urandom_range(0, 29) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL random cycle=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
    end
    k_mode = 1'b0; k_inc = 1'b0; k_dec = 1'b0; k_conf = 1'b0; rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_entry();
    test_year_wrap();
    test_leap_clamp();
    test_day_wrap();
    test_commit();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/date_set_ctrl.md
# date_set_ctrl

User-facing date-setting controller for the digital clock. Converts debounced key pulses into an edit session over a shadow copy of the calendar date (year, month, day in BCD), enforcing legal month lengths and leap years. On confirm it presents the edited date on the `*_set` buses and pulses `date_set_mod` for one cycle, which loads the date counter. It sits between the key debouncers and the date counter; in normal operation it is idle and drives no loads.

## Interface
Parameters:
- `IDLE_TIMEOUT`, 32'd500_000_000: `clk` cycles without any key pulse before an edit session is abandoned. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `key_mode`  in  1  one-cycle pulse: enter edit / advance field.
- `key_inc`  in  1  one-cycle pulse: increment current field.
- `key_dec`  in  1  one-cycle pulse: decrement current field.
- `key_confirm`  in  1  one-cycle pulse: commit the edited date.
- `year3, year2, year1, year0`  in  4 each  live date counter year, BCD.
- `month1, month0`  in  4 each  live month, BCD 01–12.
- `day1, day0`  in  4 each  live day, BCD.
- `year_set3..year_set0`  out  4 each  shadow year, BCD.
- `month_set1, month_set0`  out  4 each  shadow month.
- `day_set1, day_set0`  out  4 each  shadow day.
- `date_set_mod`  out  1  one-cycle load strobe to the date counter.
- `editing`  out  1  high while in any EDIT state.
- `field_sel`  out  2  field being edited, for display blink: 0 none, 1 year, 2 month, 3 day.

## Operation
- FSM states: IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, COMMIT.
- IDLE: on `key_mode`, copy the live date into the shadow and go to EDIT_YEAR. All other keys are ignored.
- In EDIT states, key priority per cycle is confirm > mode > inc/dec. If `key_inc` and `key_dec` arrive together, the field is unchanged.
- `key_mode` cycles the edit field: EDIT_YEAR → EDIT_MONTH → EDIT_DAY → EDIT_YEAR.
- `key_confirm` in any EDIT state goes to COMMIT.
- COMMIT lasts one cycle with `date_set_mod`=1, then returns to IDLE.
- Year range is 2000–2099. Only `year1:year0` is edited; the upper digits are forced to 2,0 on entry. Inc 2099 → 2000; dec 2000 → 2099.
- Month range 01–12 with wrap. Inc 12 → 01; dec 01 → 12.
- Day range 01..max(month, year) with wrap. Inc at max → 01; dec 01 → max.
- Month lengths: 31 for 01,03,05,07,08,10,12; 30 for 04,06,09,11; 28 for 02, or 29 in a leap year.
- Leap rule within 2000–2099: the year is leap iff the low two digits are divisible by 4. In BCD terms: (`year1` even and `year0` ∈ {0,4,8}) or (`year1` odd and `year0` ∈ {2,6}).
- Day clamp: any year or month update that makes the shadow day exceed the new maximum sets the day to that maximum in the same cycle.
- Timeout: a counter reloads on every key pulse while editing. When it reaches `IDLE_TIMEOUT`, the FSM returns to IDLE with no commit. The shadow keeps its edited contents and `date_set_mod` stays 0.
- All arithmetic is per-digit BCD. No binary conversion of the year.

## Timing
- Reset values: state IDLE; shadow = 2019-01-01 (16'h2019, 8'h01, 8'h01); `date_set_mod`=0; `editing`=0; `field_sel`=0; timeout counter 0.
- Reset in mid-session or during COMMIT aborts immediately. No strobe is issued in the cycle after reset.
- Key pulse sampled at edge N: shadow, state and `field_sel` are updated and visible after edge N+1 (one-cycle latency).
- Commit sequence:
  - `key_confirm` at edge N.
  - `date_set_mod`=1 during the cycle after edge N+1; `editing`=0 and `field_sel`=0 in that cycle.
  - IDLE after edge N+2.
- `*_set` outputs are stable from the cycle before `date_set_mod` rises until the next edit session. This gives the downstream posedge-triggered load stable data.
- Live-date inputs are sampled only at session entry.

## Structure
- Shared package `clock_pkg`:
  - state encoding `date_set_state_t`;
  - field codes FIELD_NONE/YEAR/MONTH/DAY;
  - BCD constants: min/max month, year base 8'h20, reset date 2019-01-01.
- Sub-module `month_days`: combinational; inputs month BCD and year1/year0; output max day BCD (8'h28–8'h31). Instantiate it twice:
  - for the current shadow, used by day wrap;
  - for the candidate next month/year, used by the clamp.

## Test plan
- Reset, then `key_mode` with live date 2023-06-15 → after 1 cycle `editing`=1, `field_sel`=1, shadow = 2023-06-15.
- From EDIT_YEAR at 2099: `key_inc` → year 2000. Then `key_dec` → 2099.
- Shadow 2024-01-31, advance to month, `key_inc` → 2024-02-29. Then go to year, `key_inc` → 2025-02-28 (clamp).
- EDIT_DAY, 2023-04-30: `key_inc` → day 01. `key_dec` → day 30. `key_inc`+`key_dec` together → unchanged.
- `key_confirm` at 2021-12-31 → `date_set_mod` high for exactly one cycle, outputs 16'h2021/8'h12/8'h31, then IDLE. Assert `rst` during the next session's EDIT_MONTH → IDLE and shadow 2019-01-01, with no strobe.
- `IDLE_TIMEOUT`=10, enter edit and press no keys → IDLE after 10 cycles and `date_set_mod` never asserted. A key pulse at cycle 9 restarts the count.
